mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters: the core pipeline (loads/stores) and the network packet handler (memory loads/peeks over the network).
- Policy is core-priority while the core is in RUN, with a starvation guard for the network.
- While the core is in IDLE or ERR, the network owns the port.
- Sits between the core's execute stage, the network command decoder and the data memory. Drives the stall that the core state machine consumes.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_arb_starve_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// Core state, arbitration state, read-owner tag and request bundle.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef enum logic {
    ARB_CORE_PRI = 1'b0,
    ARB_NET_TURN = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_NET  = 2'd2
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_s;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive lost network cycles.
// Flags when the count will reach the limit at the next edge.
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic net_req,
  input  logic net_gnt,
  output logic hit_next
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!net_req || net_gnt) begin
      starve_d = '0;
    end else if (starve_q < LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign hit_next = (starve_d == LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// Core has priority in RUN; a starvation guard forces network turns.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  state_e            core_state_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_stall_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              net_req_i,
  input  logic              net_we_i,
  input  logic [ADDR_W-1:0] net_addr_i,
  input  logic [DATA_W-1:0] net_wdata_i,
  output logic              net_gnt_o,
  output logic              net_rvalid_o,
  output logic [DATA_W-1:0] net_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e arb_q, arb_d;
  arb_owner_e owner_q, owner_d;
  mem_req_s   core_r, net_r, win;
  logic       core_elig;
  logic       starve_hit;

  assign core_elig = (core_state_i == RUN) & core_req_i;

  assign core_r = '{we: core_we_i, addr: core_addr_i, wdata: core_wdata_i};
  assign net_r  = '{we: net_we_i, addr: net_addr_i, wdata: net_wdata_i};

  mem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .net_req (net_req_i),
    .net_gnt (net_gnt_o),
    .hit_next(starve_hit)
  );

  always_comb begin
    core_gnt_o = 1'b0;
    net_gnt_o  = 1'b0;
    arb_d      = arb_q;
    if (!reset) begin
      unique case (arb_q)
        ARB_CORE_PRI: begin
          if (core_elig) core_gnt_o = 1'b1;
          else if (net_req_i) net_gnt_o = 1'b1;
        end
        ARB_NET_TURN: begin
          if (net_req_i) net_gnt_o = 1'b1;
          else if (core_elig) core_gnt_o = 1'b1;
        end
        default: ;
      endcase
    end
    if (net_gnt_o || !net_req_i) arb_d = ARB_CORE_PRI;
    else if (starve_hit) arb_d = ARB_NET_TURN;
  end

  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      core_gnt_o & ~core_we_i: owner_d = OWN_CORE;
      net_gnt_o & ~net_we_i:   owner_d = OWN_NET;
      default:                 owner_d = OWN_NONE;
    endcase
  end

  always_comb begin
    win = '0;
    if (core_gnt_o) win = core_r;
    else if (net_gnt_o) win = net_r;
  end

  assign mem_en_o    = core_gnt_o | net_gnt_o;
  assign mem_we_o    = win.we;
  assign mem_addr_o  = win.addr;
  assign mem_wdata_o = win.wdata;

  assign core_stall_o = core_elig & ~core_gnt_o;

  // In-flight responses are suppressed while reset is held.
  assign core_rvalid_o = (owner_q == OWN_CORE) & ~reset;
  assign net_rvalid_o  = (owner_q == OWN_NET) & ~reset;
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign net_rdata_o   = net_rvalid_o ? mem_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q   <= ARB_CORE_PRI;
      owner_q <= OWN_NONE;
    end else begin
      arb_q   <= arb_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, reference model,
// directed scenarios and randomized traffic.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  state_e        core_state = IDLE;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          net_req = 1'b0;
  logic          net_we = 1'b0;
  logic [AW-1:0] net_addr = '0;
  logic [DW-1:0] net_wdata = '0;
  logic          net_gnt, net_rvalid;
  logic [DW-1:0] net_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_state_i (core_state),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_gnt_o   (core_gnt),
    .core_stall_o (core_stall),
    .core_rvalid_o(core_rvalid),
    .core_rdata_o (core_rdata),
    .net_req_i    (net_req),
    .net_we_i     (net_we),
    .net_addr_i   (net_addr),
    .net_wdata_i  (net_wdata),
    .net_gnt_o    (net_gnt),
    .net_rvalid_o (net_rvalid),
    .net_rdata_o  (net_rdata),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 | 32'(a * 37);
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory, reloaded while reset is high
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hA5A5_A5A5;
    end
  end

  // Reference model: who must win, what reaches memory, what returns
  logic [DW-1:0] shadow [0:1023];
  bit            pend_c = 0;
  bit            pend_n = 0;
  logic [DW-1:0] pend_d = '0;
  int            lost = 0;

  always @(negedge clk) begin
    bit            ce, cw, nw, rc, rn;
    logic          xwe;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    ce = (core_state == RUN) && core_req;
    nw = !reset && net_req && (!ce || lost >= LIM);
    cw = !reset && ce && !nw;
    xwe = 1'b0;
    xa  = '0;
    xd  = '0;
    if (cw) begin
      xwe = core_we; xa = core_addr; xd = core_wdata;
    end else if (nw) begin
      xwe = net_we; xa = net_addr; xd = net_wdata;
    end
    rc = pend_c && !reset;
    rn = pend_n && !reset;
    chk("core_gnt", 32'(core_gnt), 32'(cw));
    chk("net_gnt", 32'(net_gnt), 32'(nw));
    chk("core_stall", 32'(core_stall), 32'(ce && !cw));
    chk("mem_en", 32'(mem_en), 32'(cw || nw));
    chk("mem_we", 32'(mem_we), 32'(xwe));
    chk("mem_addr", 32'(mem_addr), 32'(xa));
    chk("mem_wdata", mem_wdata, xd);
    chk("core_rvalid", 32'(core_rvalid), 32'(rc));
    chk("net_rvalid", 32'(net_rvalid), 32'(rn));
    chk("core_rdata", core_rdata, rc ? pend_d : '0);
    chk("net_rdata", net_rdata, rn ? pend_d : '0);
    if (reset) begin
      lost   = 0;
      pend_c = 0;
      pend_n = 0;
      for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    end else begin
      pend_c = cw && !core_we;
      pend_n = nw && !net_we;
      pend_d = shadow[xa];
      if ((cw || nw) && xwe) shadow[xa] = xd;
      if (net_req && !nw) lost = (lost < LIM) ? lost + 1 : LIM;
      else lost = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0;
    core_we  = 1'b0;
    net_req  = 1'b0;
    net_we   = 1'b0;
  endtask

  initial begin
    int r;
    idle();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_net_rvalid", 32'(net_rvalid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);

    // Core read in RUN
    tick();
    core_state = RUN;
    core_req = 1'b1;
    core_addr = 10'h010;
    @(negedge clk);
    chk("t1_gnt", 32'(core_gnt), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h010);
    tick();
    idle();
    @(negedge clk);
    chk("t1_rvalid", 32'(core_rvalid), 32'd1);
    chk("t1_rdata", core_rdata, 32'hDEAD_BEEF);
    chk("t1_net_rvalid", 32'(net_rvalid), 32'd0);

    // Network write while core is IDLE
    tick();
    core_state = IDLE;
    core_req = 1'b1;
    net_req = 1'b1;
    net_we = 1'b1;
    net_addr = 10'h020;
    net_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t2_net_gnt", 32'(net_gnt), 32'd1);
    chk("t2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_core_gnt", 32'(core_gnt), 32'd0);
    chk("t2_stall", 32'(core_stall), 32'd0);
    tick();
    idle();
    core_state = RUN;
    core_req = 1'b1;
    core_addr = 10'h020;
    @(negedge clk);
    chk("t2_no_rvalid", 32'(net_rvalid), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("t2_readback", core_rdata, 32'h1234_5678);

    // Contention: net forced in on the fifth cycle
    tick();
    core_req = 1'b1;
    core_addr = 10'h005;
    net_req = 1'b1;
    net_addr = 10'h006;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_core_gnt", 32'(core_gnt), 32'(i != 4));
      chk("t3_net_gnt", 32'(net_gnt), 32'(i == 4));
      chk("t3_stall", 32'(core_stall), 32'(i == 4));
      tick();
    end
    idle();

    // Alternating reads, responses routed to the right owner
    for (int k = 0; k < 5; k++) begin
      bit wasc;
      idle();
      if (k < 4) begin
        if (k % 2 == 0) begin
          core_req = 1'b1; core_addr = 10'h001;
        end else begin
          net_req = 1'b1; net_addr = 10'h002;
        end
      end
      @(negedge clk);
      if (k > 0) begin
        wasc = ((k - 1) % 2 == 0);
        chk("t4_core_rv", 32'(core_rvalid), 32'(wasc));
        chk("t4_net_rv", 32'(net_rvalid), 32'(!wasc));
        chk("t4_core_rd", core_rdata, wasc ? init_val(1) : '0);
        chk("t4_net_rd", net_rdata, wasc ? '0 : init_val(2));
      end
      tick();
    end

    // Reset right behind a net read
    idle();
    net_req = 1'b1;
    net_addr = 10'h030;
    @(negedge clk);
    chk("t5_net_gnt", 32'(net_gnt), 32'd1);
    tick();
    reset = 1'b1;
    core_req = 1'b1;
    @(negedge clk);
    chk("t5_rst_net_gnt", 32'(net_gnt), 32'd0);
    chk("t5_rst_core_gnt", 32'(core_gnt), 32'd0);
    chk("t5_rst_mem_en", 32'(mem_en), 32'd0);
    chk("t5_rst_rvalid", 32'(net_rvalid), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_rvalid2", 32'(net_rvalid), 32'd0);
    tick();
    reset = 1'b0;
    core_addr = 10'h007;
    net_addr = 10'h008;
    @(negedge clk);
    chk("t5_post_core", 32'(core_gnt), 32'd1);
    chk("t5_post_net", 32'(net_gnt), 32'd0);
    chk("t5_post_rv", 32'(net_rvalid), 32'd0);
    tick();
    idle();

    // Core in ERR, network peeks top address
    core_state = ERR;
    core_req = 1'b1;
    net_req = 1'b1;
    net_addr = 10'h3FF;
    @(negedge clk);
    chk("t6_net_gnt", 32'(net_gnt), 32'd1);
    chk("t6_core_gnt", 32'(core_gnt), 32'd0);
    chk("t6_stall", 32'(core_stall), 32'd0);
    chk("t6_addr", 32'(mem_addr), 32'h3FF);
    tick();
    idle();
    @(negedge clk);
    chk("t6_rvalid", 32'(net_rvalid), 32'd1);
    chk("t6_rdata", net_rdata, init_val(1023));
    chk("t6_core_rv", 32'(core_rvalid), 32'd0);
    tick();

    // Randomized traffic; network holds its request until granted
    for (int n = 0; n < 600; n++) begin
      bit ng;
      @(negedge clk);
      ng = net_gnt;
      tick();
      reset = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9);
      core_state = (r < 7) ? RUN : ((r < 9) ? IDLE : ERR);
      core_req = 1'($urandom_range(0, 1));
      core_we = ($urandom_range(0, 3) == 0);
      core_addr = 10'($urandom_range(0, 31));
      core_wdata = $urandom;
      if (!net_req || ng) begin
        net_req = ($urandom_range(0, 99) < 60);
        net_we = ($urandom_range(0, 3) == 0);
        net_addr = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 31));
        net_wdata = $urandom;
      end
    end
    reset = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
